mips_single_cycle_core: RTL and testbench
=========================================

# mips_single_cycle_core

Single-cycle 32-bit MIPS subset processor core: main control decoder, ALU-control decoder and datapath (PC, instruction memory, register file, ALU, data memory, branch logic) in one block. It is the body of the top-level CPU wrapper and executes one instruction per clock. Debug ports expose PC, the current instruction and one register read for verification.

## Interface
- No parameters.
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset, sampled on rising clock edge.
- pc  out  32  current program counter.
- instr  out  32  instruction currently fetched (imem[pc[11:2]]).
- dbg_ra  in  5  debug register-file read address.
- dbg_rd  out  32  register-file contents at dbg_ra (combinational; 0 for address 0).

## Operation
- Memories: imem and dmem, 1024 x 32-bit words each, word index = byte address [11:2]; address bits [31:12] and [1:0] ignored. Contents not cleared by reset; loaded by the bench hierarchically via $readmemh on arrays named imem and dmem.
- Register file: 32 x 32. r0 always reads 0; writes to r0 ignored. During reset, ri = i for i = 1..31.
- Main decoder (op = instr[31:26]), outputs RegWrite, RegDst, AluSrc, MemWrite, MemToReg, Branch[1:0] (bit0 beq, bit1 bne), alu_op[1:0]:
  - 000000 R-type: RegWrite 1, RegDst 1 (dest rd), AluSrc 0, alu_op 10.
  - 100011 lw: RegWrite 1, RegDst 0 (dest rt), AluSrc 1, MemToReg 1, alu_op 00.
  - 101011 sw: MemWrite 1, AluSrc 1, alu_op 00.
  - 001000 addi: RegWrite 1, RegDst 0, AluSrc 1, alu_op 00.
  - 000100 beq: Branch 01, alu_op 01. 000101 bne: Branch 10, alu_op 01.
  - any other opcode: all enables 0 (NOP), PC+4.
- ALU decoder: alu_op 00 -> 0010 add; 01 -> 0110 sub; 10 decodes funct instr[5:0]: 100000 add 0010, 100010 sub 0110, 100100 and 0000, 100101 or 0001, 101010 slt 0111, 100111 nor 1100. Unknown funct -> 1111, ALU output 0, RegWrite suppressed.
- ALU: inA = rs, inB = AluSrc ? sign-extended imm16 : rt. add/sub wrap mod 2^32, no overflow trap. slt signed: out = 1 if signed(inA) < signed(inB) else 0. zero = (out == 0).
- Write-back data = MemToReg ? dmem[aluout[11:2]] : aluout.
- Next PC: taken = (Branch[0] & zero) | (Branch[1] & ~zero); pc_next = taken ? pc+4 + (signext(imm16) << 2) : pc+4. Wraps mod 2^32.

## Timing
- CPI = 1. Fetch, decode, ALU, dmem read all combinational within the cycle.
- Rising edge with reset high: pc <= pc_next, register write (if RegWrite and dest != 0), dmem write (if MemWrite).
- Rising edge with reset low: pc <= 0, registers reinitialised, no dmem write; same behaviour when reset asserts mid-program.
- Read-during-write: reads in a cycle return the old value; write visible next cycle.
- Reset values: pc = 0, instr = imem[0], dbg_rd = dbg_ra.

## Configuration
- MIPS_BNE_EN: defined -> opcode 000101 decoded as bne as above. Undefined -> 000101 treated as unknown opcode (NOP, PC+4), Branch[1] tied 0.

## Test plan
- Reset: hold reset low 2 cycles -> pc = 0, dbg_rd at ra 5 = 5, at ra 31 = 31, at ra 0 = 0.
- R-type: add r3,r5,r7; sub r4,r7,r5; nor r6,r0,r0 -> r3 = 12, r4 = 2, r6 = 0xFFFFFFFF; pc advances 4 per cycle.
- slt signed: addi r8,r0,-1; slt r9,r8,r1 -> r8 = 0xFFFFFFFF, r9 = 1; slt r10,r1,r8 -> r10 = 0.
- Memory: sw r7,8(r0); lw r11,8(r0) -> dmem[2] = 7, r11 = 7; write to r0 leaves r0 = 0.
- Branches: beq r5,r5,+2 at pc 0x10 -> next pc 0x1C; beq r5,r7 -> 0x14; with MIPS_BNE_EN bne r5,r7,-1 at 0x20 -> 0x20, without it -> 0x24.
- Reset mid-program after r3 written: pulse reset one cycle -> pc = 0, r3 = 3.

Source files
------------

// File: rtl/mips_single_cycle_core_if.sv
// Debug/observation bundle for mips_single_cycle_core: PC, fetched instruction
// and one combinational register-file read port.
interface mips_single_cycle_core_if;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [4:0]  dbg_ra;
  logic [31:0] dbg_rd;

  modport master (input pc, input instr, input dbg_rd, output dbg_ra);
  modport slave  (output pc, output instr, output dbg_rd, input dbg_ra);
endinterface

// File: rtl/mips_single_cycle_core.sv
// Single-cycle MIPS subset core (R-type add/sub/and/or/slt/nor, lw, sw, addi, beq, bne).
// Optional feature: define MIPS_BNE_EN to decode opcode 000101 as bne.
module mips_single_cycle_core (
  input  logic                     clock,
  input  logic                     reset,
  mips_single_cycle_core_if.slave  dbg
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011,
    OP_ADDI  = 6'b001000,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101
  } opcode_e;

  typedef enum logic [5:0] {
    FN_ADD = 6'b100000,
    FN_SUB = 6'b100010,
    FN_AND = 6'b100100,
    FN_OR  = 6'b100101,
    FN_SLT = 6'b101010,
    FN_NOR = 6'b100111
  } funct_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100,
    ALU_BAD = 4'b1111
  } alu_ctl_e;

  logic [31:0] imem [0:1023];
  logic [31:0] dmem [0:1023];
  logic [31:0] rf   [0:31];

  logic [31:0] pc_r;
  logic [31:0] instr;
  logic [4:0]  rs, rt, rd, dest;
  logic [15:0] imm16;
  logic [31:0] imm_ext;
  logic [31:0] rs_val, rt_val;

  logic        reg_write, reg_dst, alu_src, mem_write, mem_to_reg;
  logic [1:0]  branch;
  logic [1:0]  alu_op;
  alu_ctl_e    alu_ctl;
  logic        reg_write_eff;

  logic [31:0] alu_b, alu_out, wb_data;
  logic        zero, taken;
  logic [31:0] pc_plus4, pc_branch, pc_next;

  assign instr   = imem[pc_r[11:2]];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign imm16   = instr[15:0];
  assign imm_ext = {{16{imm16[15]}}, imm16};

  assign rs_val = (rs == 5'd0) ? '0 : rf[rs];
  assign rt_val = (rt == 5'd0) ? '0 : rf[rt];

  assign dbg.pc     = pc_r;
  assign dbg.instr  = instr;
  assign dbg.dbg_rd = (dbg.dbg_ra == 5'd0) ? '0 : rf[dbg.dbg_ra];

  // Main decoder: anything not listed falls through as a NOP.
  always_comb begin
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 2'b00;
    alu_op     = 2'b00;
    case (instr[31:26])
      OP_RTYPE: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        alu_op    = 2'b10;
      end
      OP_LW: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        mem_to_reg = 1'b1;
      end
      OP_SW: begin
        mem_write = 1'b1;
        alu_src   = 1'b1;
      end
      OP_ADDI: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
      end
      OP_BEQ: begin
        branch = 2'b01;
        alu_op = 2'b01;
      end
`ifdef MIPS_BNE_EN
      OP_BNE: begin
        branch = 2'b10;
        alu_op = 2'b01;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    alu_ctl = ALU_BAD;
    case (alu_op)
      2'b00: alu_ctl = ALU_ADD;
      2'b01: alu_ctl = ALU_SUB;
      default: begin
        case (instr[5:0])
          FN_ADD:  alu_ctl = ALU_ADD;
          FN_SUB:  alu_ctl = ALU_SUB;
          FN_AND:  alu_ctl = ALU_AND;
          FN_OR:   alu_ctl = ALU_OR;
          FN_SLT:  alu_ctl = ALU_SLT;
          FN_NOR:  alu_ctl = ALU_NOR;
          default: alu_ctl = ALU_BAD;
        endcase
      end
    endcase
  end

  assign alu_b = alu_src ? imm_ext : rt_val;

  always_comb begin
    alu_out = '0;
    case (alu_ctl)
      ALU_AND: alu_out = rs_val & alu_b;
      ALU_OR:  alu_out = rs_val | alu_b;
      ALU_ADD: alu_out = rs_val + alu_b;
      ALU_SUB: alu_out = rs_val - alu_b;
      ALU_SLT: alu_out = {31'd0, $signed(rs_val) < $signed(alu_b)};
      ALU_NOR: alu_out = ~(rs_val | alu_b);
      default: alu_out = '0;
    endcase
  end

  assign zero          = (alu_out == '0);
  assign reg_write_eff = reg_write & (alu_ctl != ALU_BAD);
  assign dest          = reg_dst ? rd : rt;
  assign wb_data       = mem_to_reg ? dmem[alu_out[11:2]] : alu_out;

  assign taken     = (branch[0] & zero) | (branch[1] & ~zero);
  assign pc_plus4  = pc_r + 32'd4;
  assign pc_branch = pc_plus4 + {imm_ext[29:0], 2'b00};
  assign pc_next   = taken ? pc_branch : pc_plus4;

  always_ff @(posedge clock) begin
    if (!reset) pc_r <= '0;
    else        pc_r <= pc_next;
  end

  // Reset reloads ri = i so programs can use registers as known constants.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) rf[i] <= 32'(i);
    end else if (reg_write_eff && dest != 5'd0) begin
      rf[dest] <= wb_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && mem_write) dmem[alu_out[11:2]] <= rt_val;
  end

endmodule

// File: tb/tb_mips_single_cycle_core.sv
// Directed bench for mips_single_cycle_core with a queue scoreboard of expected values.
module tb_mips_single_cycle_core;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clock;
  logic reset;
  mips_single_cycle_core_if bus ();

  mips_single_cycle_core dut (
    .clock (clock),
    .reset (reset),
    .dbg   (bus)
  );

  exp_t        sb[$];
  logic [31:0] prog [0:1023];
  int          checks = 0;
  int          errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %h expected <entry>", obs);
    end else begin
      e = sb.pop_front();
      checks++;
      assert (obs === e.val)
        else begin
          errors++;
          $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
        end
    end
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] ra, input logic [31:0] v);
    push(tag, v);
    bus.dbg_ra = ra;
    #1;
    check(bus.dbg_rd);
  endtask

  task automatic chk_pc(input string tag, input logic [31:0] v);
    push(tag, v);
    check(bus.pc);
    push({tag, "_instr"}, prog[v[11:2]]);
    check(bus.instr);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    bus.dbg_ra = '0;
    for (int i = 0; i < 1024; i++) prog[i] = '0;
    prog[0]  = rtype(5, 7, 3, 6'h20);                  // add r3,r5,r7
    prog[1]  = rtype(7, 5, 4, 6'h22);                  // sub r4,r7,r5
    prog[2]  = rtype(0, 0, 6, 6'h27);                  // nor r6,r0,r0
    prog[3]  = itype(6'b001000, 0, 8, 16'hFFFF);       // addi r8,r0,-1
    prog[4]  = itype(6'b000100, 5, 5, 16'd2);          // beq r5,r5,+2
    prog[5]  = itype(6'b001000, 0, 12, 16'h0055);      // skipped
    prog[6]  = itype(6'b001000, 0, 12, 16'h0066);      // skipped
    prog[7]  = rtype(8, 1, 9, 6'h2A);                  // slt r9,r8,r1
    prog[8]  = rtype(1, 8, 10, 6'h2A);                 // slt r10,r1,r8
    prog[9]  = itype(6'b101011, 0, 7, 16'd8);          // sw r7,8(r0)
    prog[10] = itype(6'b100011, 0, 11, 16'd8);         // lw r11,8(r0)
    prog[11] = itype(6'b001000, 0, 0, 16'd5);          // addi r0,r0,5
    prog[12] = itype(6'b000100, 5, 7, 16'd4);          // beq r5,r7 (not taken)
    prog[13] = rtype(5, 7, 13, 6'h01);                 // unknown funct
    prog[14] = itype(6'b001111, 0, 14, 16'h1234);      // unknown opcode
    prog[15] = itype(6'b000101, 5, 7, 16'hFFFF);       // bne r5,r7,-1
    for (int i = 0; i < 1024; i++) begin
      dut.imem[i] = prog[i];
      dut.dmem[i] = '0;
    end

    step();
    step();
    chk_pc("rst_pc", 32'h0);
    chk_reg("rst_r5", 5, 32'd5);
    chk_reg("rst_r31", 31, 32'd31);
    chk_reg("rst_r0", 0, 32'd0);
    reset = 1'b1;

    step(); chk_pc("add_pc", 32'h04);  chk_reg("add_r3", 3, 32'd12);
    step(); chk_pc("sub_pc", 32'h08);  chk_reg("sub_r4", 4, 32'd2);
    step(); chk_pc("nor_pc", 32'h0C);  chk_reg("nor_r6", 6, 32'hFFFF_FFFF);
    step(); chk_pc("addi_pc", 32'h10); chk_reg("addi_r8", 8, 32'hFFFF_FFFF);
    step(); chk_pc("beq_taken_pc", 32'h1C); chk_reg("skip_r12", 12, 32'd12);
    step(); chk_pc("slt1_pc", 32'h20); chk_reg("slt_r9", 9, 32'd1);
    step(); chk_pc("slt2_pc", 32'h24); chk_reg("slt_r10", 10, 32'd0);
    step(); chk_pc("sw_pc", 32'h28);
    push("sw_dmem2", 32'd7); check(dut.dmem[2]);
    step(); chk_pc("lw_pc", 32'h2C);   chk_reg("lw_r11", 11, 32'd7);
    step(); chk_pc("wr0_pc", 32'h30);  chk_reg("wr0_r0", 0, 32'd0);
    step(); chk_pc("beq_nt_pc", 32'h34); chk_reg("beq_nt_r5", 5, 32'd5);
    step(); chk_pc("badfn_pc", 32'h38); chk_reg("badfn_r13", 13, 32'd13);
    step(); chk_pc("badop_pc", 32'h3C); chk_reg("badop_r14", 14, 32'd14);
`ifdef MIPS_BNE_EN
    step(); chk_pc("bne_pc", 32'h3C);
    step(); chk_pc("bne_again_pc", 32'h3C);
`else
    step(); chk_pc("bne_off_pc", 32'h40);
    step(); chk_pc("nop_pc", 32'h44);
`endif
    chk_reg("pre_rst_r3", 3, 32'd12);

    reset = 1'b0;
    step();
    reset = 1'b1;
    chk_pc("mid_rst_pc", 32'h0);
    chk_reg("mid_rst_r3", 3, 32'd3);
    chk_reg("mid_rst_r8", 8, 32'd8);
    step(); chk_pc("rerun_pc", 32'h04); chk_reg("rerun_r3", 3, 32'd12);

    if (sb.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
